// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate / branch-target generator for the pipelined
//   SimpleRISC core, placed between decode and operand-fetch. An entry
//   {pc, instruction, CSR-writeback flag, call flag} is accepted under a
//   valid/ready handshake. One cycle later the block presents the extended
//   immediate, the branch/call target and a flag that says whether pc+offset
//   wrapped around the XLEN-bit address space.
//
// Parameters
//   XLEN      datapath width of pc / immx / target (>= 32)
//   OFF_SHIFT left shift of the sign-extended 27-bit branch offset (0..2)
//   SKID      1: two-entry buffer (output + skid), in_ready from a register
//             0: single output register, in_ready combinational
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of every held entry and of the
//                         entry offered in the same cycle
//   in_valid / in_ready   upstream handshake
//   in_pc, in_instr       pc and instruction word
//   in_is_wb_csr          CSR-writeback instruction (enables ones-fill)
//   in_is_call            call instruction (target is the bare offset)
//   out_valid / out_ready downstream handshake
//   out_immx              generated immediate
//   out_branch_target     branch / call target
//   out_tgt_wrap          pc+offset wrapped modulo 2^XLEN
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int OFF_SHIFT = 0,
    parameter int SKID      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            in_is_wb_csr,
    input  logic            in_is_call,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_immx,
    output logic [XLEN-1:0] out_branch_target,
    output logic            out_tgt_wrap
);

    localparam logic SKID_EN = (SKID != 0) ? 1'b1 : 1'b0;

    // Combinational datapath
    logic [15:0]     imm_s;
    logic [1:0]      mod_s;
    logic            fill_s;
    logic [XLEN-1:0] immx_s;
    logic [XLEN-1:0] off_ext_s;
    logic [XLEN-1:0] off_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN-1:0] target_s;
    logic            wrap_s;

    // Handshake
    logic            in_ready_s;
    logic            load_out_s;
    logic            offer_s;

    // Output register
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_immx_q, out_immx_d;
    logic [XLEN-1:0] out_tgt_q, out_tgt_d;
    logic            out_wrap_q, out_wrap_d;

    // Skid register (stays empty when SKID = 0)
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_immx_q, skid_immx_d;
    logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;
    logic            skid_wrap_q, skid_wrap_d;

    assign imm_s  = in_instr[15:0];
    assign mod_s  = in_instr[17:16];
    assign fill_s = in_is_wb_csr & in_instr[18];

    // Immediate extension selected by the two mode bits
    always_comb begin
        immx_s = {XLEN{1'b0}};
        case (mod_s)
            2'b00: begin
                if (fill_s) begin
                    immx_s = {{(XLEN-16){1'b1}}, imm_s};
                end else begin
                    immx_s = {{(XLEN-16){imm_s[15]}}, imm_s};
                end
            end
            2'b10: begin
                // Upper-half immediate; anything above bit 31 stays zero.
                immx_s[31:16] = imm_s;
                if (fill_s) begin
                    immx_s[15:0] = 16'hFFFF;
                end else begin
                    immx_s[15:0] = 16'h0000;
                end
            end
            default: begin
                immx_s = {{(XLEN-16){1'b0}}, imm_s};
            end
        endcase
    end

    // Sign-extended 27-bit offset; with OFF_SHIFT <= 2 and XLEN >= 32 the
    // shift never disturbs the sign bit, so off_s[XLEN-1] is the offset sign.
    assign off_ext_s = {{(XLEN-27){in_instr[26]}}, in_instr[26:0]};
    assign off_s     = off_ext_s << OFF_SHIFT;
    assign sum_s     = {1'b0, in_pc} + {1'b0, off_s};

    // Target select and wrap detection (carry for forward, borrow for backward)
    always_comb begin
        target_s = {XLEN{1'b0}};
        wrap_s   = 1'b0;
        if (in_is_call) begin
            target_s = off_s;
            wrap_s   = 1'b0;
        end else begin
            target_s = sum_s[XLEN-1:0];
            if (off_s[XLEN-1]) begin
                wrap_s = (sum_s[XLEN-1:0] > in_pc);
            end else begin
                wrap_s = sum_s[XLEN];
            end
        end
    end

    // With a skid buffer in_ready depends only on state, breaking the
    // out_ready -> in_ready combinational path.
    always_comb begin
        if (SKID_EN) begin
            in_ready_s = ~skid_valid_q;
        end else begin
            in_ready_s = ~out_valid_q | out_ready;
        end
    end

    assign load_out_s = ~out_valid_q | out_ready;
    assign offer_s    = in_valid & in_ready_s;

    // Next-state for output and skid registers; flush beats everything
    always_comb begin
        out_valid_d  = out_valid_q;
        out_immx_d   = out_immx_q;
        out_tgt_d    = out_tgt_q;
        out_wrap_d   = out_wrap_q;
        skid_valid_d = skid_valid_q;
        skid_immx_d  = skid_immx_q;
        skid_tgt_d   = skid_tgt_q;
        skid_wrap_d  = skid_wrap_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out_s) begin
            if (skid_valid_q) begin
                // Older entry in the skid goes out first to keep FIFO order.
                out_valid_d  = 1'b1;
                out_immx_d   = skid_immx_q;
                out_tgt_d    = skid_tgt_q;
                out_wrap_d   = skid_wrap_q;
                skid_valid_d = 1'b0;
            end else if (offer_s) begin
                out_valid_d = 1'b1;
                out_immx_d  = immx_s;
                out_tgt_d   = target_s;
                out_wrap_d  = wrap_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (SKID_EN && offer_s) begin
            // Output stalled: park the new entry behind it.
            skid_valid_d = 1'b1;
            skid_immx_d  = immx_s;
            skid_tgt_d   = target_s;
            skid_wrap_d  = wrap_s;
        end else begin
            out_valid_d  = out_valid_q;
            skid_valid_d = skid_valid_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_immx_q   <= {XLEN{1'b0}};
            out_tgt_q    <= {XLEN{1'b0}};
            out_wrap_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_immx_q  <= {XLEN{1'b0}};
            skid_tgt_q   <= {XLEN{1'b0}};
            skid_wrap_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_immx_q   <= out_immx_d;
            out_tgt_q    <= out_tgt_d;
            out_wrap_q   <= out_wrap_d;
            skid_valid_q <= skid_valid_d;
            skid_immx_q  <= skid_immx_d;
            skid_tgt_q   <= skid_tgt_d;
            skid_wrap_q  <= skid_wrap_d;
        end
    end

    assign in_ready          = in_ready_s;
    assign out_valid         = out_valid_q;
    assign out_immx          = out_immx_q;
    assign out_branch_target = out_tgt_q;
    assign out_tgt_wrap      = out_wrap_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Scoreboard bench. dut_a uses defaults (SKID=1, OFF_SHIFT=0) with a
//   driven out_ready; dut_b (SKID=0, OFF_SHIFT=2) shares the inputs with
//   out_ready tied high. A reference model computes results arithmetically
//   and a negedge monitor compares outputs and occupancy against queues.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] immx;
        logic [31:0] tgt;
        logic        wrap;
    } res_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        csr;
        logic        call;
        res_t        exp;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic        in_is_wb_csr = 1'b0;
    logic        in_is_call = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready_b = 1'b1;

    logic        in_ready_a, out_valid_a, wrap_a;
    logic [31:0] immx_a, tgt_a;
    logic        in_ready_b, out_valid_b, wrap_b;
    logic [31:0] immx_b, tgt_b;

    int vectors = 0;
    int miscompares = 0;

    res_t q_a[$];
    res_t q_b[$];
    logic ov_a_en = 1'b0;
    logic ov_b_en = 1'b0;
    res_t ov_a, ov_b;

    imm_gen_pipe dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(in_pc), .in_instr(in_instr),
        .in_is_wb_csr(in_is_wb_csr), .in_is_call(in_is_call),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_immx(immx_a), .out_branch_target(tgt_a), .out_tgt_wrap(wrap_a)
    );

    imm_gen_pipe #(.XLEN(32), .OFF_SHIFT(2), .SKID(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_instr(in_instr),
        .in_is_wb_csr(in_is_wb_csr), .in_is_call(in_is_call),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_immx(immx_b), .out_branch_target(tgt_b), .out_tgt_wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the immediate / offset / wrap rules.
    function automatic res_t ref_model(input logic [31:0] pc, input logic [31:0] instr,
                                       input logic csr, input logic call, input int sh);
        res_t   r;
        longint imm, o, sum;
        logic   fill;
        imm  = longint'(instr[15:0]);
        fill = csr & instr[18];
        case (instr[17:16])
            2'd0:    r.immx = fill ? (32'hFFFF_0000 | 32'(imm))
                                   : 32'((imm >= 32768) ? imm - 65536 : imm);
            2'd2:    r.immx = 32'(imm * 65536 + (fill ? 65535 : 0));
            default: r.immx = 32'(imm);
        endcase
        o = longint'(instr[26:0]);
        if (o >= 67108864) o = o - 134217728;
        o = o * (longint'(1) << sh);
        if (call) begin
            r.tgt  = 32'(o);
            r.wrap = 1'b0;
        end else begin
            sum    = longint'(pc) + o;
            r.tgt  = 32'(sum);
            r.wrap = (o >= 0) ? (sum >= 64'sd4294967296) : (longint'(r.tgt) > longint'(pc));
        end
        return r;
    endfunction

    // Monitor: occupancy, output data and scoreboard bookkeeping per cycle.
    always @(negedge clk) begin
        int  sz_a;
        res_t e;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            chk("rst_in_ready", in_ready_a, 1);
            chk("rst_out_valid", out_valid_a, 0);
            chk("rst_immx", immx_a, 0);
            chk("rst_target", tgt_a, 0);
            chk("rst_wrap", wrap_a, 0);
        end else if (flush) begin
            q_a.delete();
            q_b.delete();
        end else begin
            sz_a = q_a.size();
            chk("a_in_ready", in_ready_a, (sz_a < 2) ? 1 : 0);
            chk("a_out_valid", out_valid_a, (sz_a > 0) ? 1 : 0);
            if (out_valid_a && sz_a > 0) begin
                e = q_a[0];
                chk("a_immx", immx_a, e.immx);
                chk("a_target", tgt_a, e.tgt);
                chk("a_wrap", wrap_a, e.wrap);
                if (out_ready) void'(q_a.pop_front());
            end
            chk("b_in_ready", in_ready_b, 1);
            chk("b_out_valid", out_valid_b, (q_b.size() > 0) ? 1 : 0);
            if (out_valid_b && q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_immx", immx_b, e.immx);
                chk("b_target", tgt_b, e.tgt);
                chk("b_wrap", wrap_b, e.wrap);
            end
            if (in_valid && sz_a < 2)
                q_a.push_back(ov_a_en ? ov_a : ref_model(in_pc, in_instr, in_is_wb_csr, in_is_call, 0));
            if (in_valid)
                q_b.push_back(ov_b_en ? ov_b : ref_model(in_pc, in_instr, in_is_wb_csr, in_is_call, 2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one entry and hold it until dut_a takes it (bounded wait).
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                         input logic csr, input logic call, input bit rnd);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_pc = pc;
        in_instr = instr;
        in_is_wb_csr = csr;
        in_is_call = call;
        while (!done) begin
            @(negedge clk);
            done = in_ready_a && !flush;
            cyc();
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            n++;
            if (!done && n > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", n);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        ov_a_en = 1'b0;
        ov_b_en = 1'b0;
    endtask

    dir_t dirs[8];

    initial begin
        dirs[0] = '{32'h0000_0100, 32'h0000_8001, 1'b0, 1'b0, '{32'hFFFF_8001, 32'h0000_8101, 1'b0}};
        dirs[1] = '{32'h0000_1000, 32'h0006_1234, 1'b1, 1'b0, '{32'h1234_FFFF, 32'h0006_2234, 1'b0}};
        dirs[2] = '{32'h0000_1000, 32'h0006_1234, 1'b0, 1'b0, '{32'h1234_0000, 32'h0006_2234, 1'b0}};
        dirs[3] = '{32'h0000_0500, 32'h0400_0010, 1'b0, 1'b1, '{32'h0000_0010, 32'hFC00_0010, 1'b0}};
        dirs[4] = '{32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, '{32'h0000_0020, 32'h0000_0010, 1'b1}};
        dirs[5] = '{32'h0000_0008, 32'h07FF_FFF0, 1'b0, 1'b0, '{32'h0000_FFF0, 32'hFFFF_FFF8, 1'b1}};
        dirs[6] = '{32'h0000_0000, 32'h0001_8000, 1'b0, 1'b0, '{32'h0000_8000, 32'h0001_8000, 1'b0}};
        dirs[7] = '{32'h0000_0010, 32'h0004_0005, 1'b1, 1'b0, '{32'hFFFF_0005, 32'h0004_0015, 1'b0}};

        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Directed vectors with hand-derived results
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ov_a_en = 1'b1;
            ov_a = dirs[i].exp;
            if (i == 3) begin
                ov_b_en = 1'b1;
                ov_b = '{32'h0000_0010, 32'hF000_0040, 1'b0};
            end
            issue(dirs[i].pc, dirs[i].instr, dirs[i].csr, dirs[i].call, 1'b0);
            cyc();
        end

        // Skid: A held, B parked, C stalled, then drained in order
        out_ready = 1'b0;
        issue(32'h0000_0100, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0200, 32'h0001_0022, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_pc = 32'h0000_0300;
        in_instr = 32'h0002_0033;
        repeat (2) cyc();
        out_ready = 1'b1;
        issue(32'h0000_0300, 32'h0002_0033, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();

        // Flush with both entries full and a new input offered
        out_ready = 1'b0;
        issue(32'h0000_0400, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0500, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_pc = 32'h0000_0600;
        in_instr = 32'h0000_0066;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (2) cyc();

        // Asynchronous reset in the middle of a cycle with both entries full
        issue(32'h0000_0700, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0800, 32'h0000_0088, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid_a, 0);
        chk("async_immx", immx_a, 0);
        chk("async_target", tgt_a, 0);
        chk("async_wrap", wrap_a, 0);
        chk("async_in_ready", in_ready_a, 1);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 4) == 0) begin
                out_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end else begin
                pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                 : 32'($urandom);
                issue(pc, 32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            end
        end

        out_ready = 1'b1;
        repeat (5) cyc();
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised successor to the single-cycle immediate/branch-target generator, built for the pipelined SimpleRISC core.
- Sits between decode and operand-fetch.
- Accepts {pc, instruction, isWbCsr, isCall} under a valid/ready handshake and produces immx, branch target and a wrap flag one cycle later.
- Adds XLEN scaling, a configurable branch-offset shift, an optional skid buffer, a flush and a target-wrap flag.

Parameters:
- XLEN, 32: datapath width for pc, immx and target; legal values ≥32.
- OFF_SHIFT, 0: left shift applied to the sign-extended 27-bit branch offset; legal 0..2.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept this cycle
- in_pc  in  XLEN  pc of instruction
- in_instr  in  32  instruction word
- in_is_wb_csr  in  1  CSR-writeback instruction
- in_is_call  in  1  call instruction (absolute target)
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_immx  out  XLEN  generated immediate
- out_branch_target  out  XLEN  branch/call target
- out_tgt_wrap  out  1  pc+offset wrapped modulo 2^XLEN

Behaviour:
- Datapath:
  - imm = instr[15:0]; mod = instr[17:16]; fill = in_is_wb_csr & instr[18].
  - mod 00: fill ? {ones above bit15, imm} : sign-extend imm to XLEN.
  - mod 01 or 11: zero-extend imm.
  - mod 10: bits[31:16]=imm; bits[15:0]=fill ? 16'hFFFF : 0; bits above 31 = 0.
- Offset:
  - off = sign-extend instr[26:0] to XLEN, then << OFF_SHIFT, truncated to XLEN.
  - Target = in_is_call ? off : (in_pc + off) mod 2^XLEN.
- Wrap flag:
  - 0 if call.
  - Otherwise 1 when off ≥ 0 and the add carries out, or off < 0 and the unsigned result > in_pc.
- All three results are computed combinationally from inputs and captured in the output register. Latency: exactly 1 cycle from accept to out_valid.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - If !out_valid or out_ready: the output register loads the skid entry if skid_valid, else the accepted input, else out_valid clears.
  - If out_valid & !out_ready & accept: the input is captured into the skid register.
  - Order strictly FIFO; no entry dropped or duplicated.
- SKID=0: in_ready = !out_valid | out_ready; no skid register.
- out_* data holds stable while out_valid & !out_ready.
- flush: next edge clears out_valid and skid_valid. An input presented the same cycle is discarded, even if in_ready was high. Flush overrides accept and transfer.
- Reset (async assert, sync deassert at integration level):
  - out_valid=0, skid_valid=0, out_immx=0, out_branch_target=0, out_tgt_wrap=0.
  - in_ready reads 1 while in reset.
- Reset mid-stream discards all held entries immediately, without waiting for a clock.
- Simultaneous transfer and accept with the skid empty: the output register reloads with the new input; throughput is 1 per cycle.

Test Plan:
- pc=0x100, instr=0x00008001, csr=0, call=0 -> after 1 cycle out_immx=0xFFFF8001, target=0x8101, wrap=0.
- pc=0x1000, instr=0x00061234, csr=1 -> immx=0x1234FFFF, target=0x62234. Same with csr=0 -> immx=0x12340000.
- instr=0x04000010, call=1, pc=0x500 -> target=0xFC000010, immx=0x10, wrap=0. With OFF_SHIFT=2 -> target=0xF0000040.
- pc=0xFFFFFFF0, instr=0x00000020 -> target=0x10, wrap=1. pc=0x8, instr=0x07FFFFF0 (off=−16) -> target=0xFFFFFFF8, wrap=1.
- SKID=1, out_ready low 3 cycles, 3 back-to-back inputs A,B,C:
  - A is held at the output, B in the skid, in_ready=0; C is stalled upstream.
  - When out_ready rises, the output sequence is A,B,C with no gaps beyond one cycle.
- Output and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, nothing emitted. Repeat the fill, then assert rst_n=0 mid-cycle -> out_valid drops immediately and all outputs read 0.
